// File: rtl/ring_sequencer_pkg.sv
// Shared types and widths for the ring head-of-chain sequencer.
package ring_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int TIMER_W = 24;
    localparam int CNT_W   = 16;

endpackage

// File: rtl/ring_fifo.sv
// Synchronous first-word fall-through FIFO; a full FIFO refuses writes even if
// a read happens in the same cycle.
module ring_fifo #(
    parameter int W  = 9,
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic          o_rd_valid,
    output logic          o_full,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ok, rd_ok;

    always_comb begin
        o_full     = (count_q == DEPTH);
        o_rd_valid = (count_q != '0);
        wr_ok      = i_wr_en && !o_full;
        rd_ok      = i_rd_en && o_rd_valid;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rd_ptr_q];
    assign o_count   = count_q;

endmodule

// File: rtl/ring_sequencer.sv
// Head-of-ring controller: issues the single token, counts returns, regenerates
// on timeout, and buffers ring bytes toward an AXI-Stream sink.
module ring_sequencer
    import ring_sequencer_pkg::*;
#(
    parameter int DW       = 8,
    parameter int FIFO_AW  = 9,
    parameter int RESERVE  = 256,
    parameter int TIMEOUT  = 65535
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DW-1:0]    i_data,
    input  logic             i_last,
    input  logic             i_valid,
    input  logic             i_token,
    output logic             o_token,
    output logic [DW-1:0]    o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic [CNT_W-1:0] o_rounds,
    output logic [CNT_W-1:0] o_msgs,
    output logic             o_timeout,
    output logic             o_overflow
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               token_q, token_d;
    logic [CNT_W-1:0]   rounds_q, rounds_d;
    logic [CNT_W-1:0]   msgs_q, msgs_d;
    logic               timeout_q, timeout_d;
    logic               overflow_q, overflow_d;

    logic [DW:0]        fifo_rd_data;
    logic               fifo_full;
    logic [FIFO_AW:0]   fifo_count;
    logic [FIFO_AW:0]   free;
    logic               free_ok;
    logic               wr_accept;

    ring_fifo #(
        .W  (DW + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_valid),
        .i_wr_data  ({i_last, i_data}),
        .i_rd_en    (i_tready),
        .o_rd_data  (fifo_rd_data),
        .o_rd_valid (o_tvalid),
        .o_full     (fifo_full),
        .o_count    (fifo_count)
    );

    always_comb begin
        free      = DEPTH - fifo_count;
        // Compare at 32 bits so a RESERVE larger than the FIFO simply never issues.
        free_ok   = (32'(free) >= 32'(RESERVE));
        wr_accept = i_valid && !fifo_full;

        state_d    = state_q;
        timer_d    = timer_q;
        rounds_d   = rounds_q;
        msgs_d     = msgs_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;

        if (wr_accept && i_last) msgs_d = msgs_q + 1'b1;
        if (i_valid && fifo_full) overflow_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (i_en && free_ok) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                timer_d = TIMER_W'(TIMEOUT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A return on the final timer cycle still counts as a round.
                if (i_token) begin
                    rounds_d = rounds_q + 1'b1;
                    state_d  = ST_IDLE;
                end else if (timer_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        token_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            token_q    <= 1'b0;
            rounds_q   <= '0;
            msgs_q     <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            token_q    <= token_d;
            rounds_q   <= rounds_d;
            msgs_q     <= msgs_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_token    = token_q;
    assign o_tdata    = fifo_rd_data[DW-1:0];
    assign o_tlast    = fifo_rd_data[DW];
    assign o_rounds   = rounds_q;
    assign o_msgs     = msgs_q;
    assign o_timeout  = timeout_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_ring_sequencer.sv
// Bench for ring_sequencer: two instances (roomy FIFO / tiny FIFO with short
// timeout) share stimulus; a stream scoreboard checks whichever one is selected.
module tb_ring_sequencer;

    logic       clk = 1'b0;
    logic       rst, en, last, valid, token, tready;
    logic [7:0] data;

    logic        a_token, a_tlast, a_tvalid, a_timeout, a_overflow;
    logic [7:0]  a_tdata;
    logic [15:0] a_rounds, a_msgs;
    logic        b_token, b_tlast, b_tvalid, b_timeout, b_overflow;
    logic [7:0]  b_tdata;
    logic [15:0] b_rounds, b_msgs;

    logic        m_token, m_tlast, m_tvalid, m_timeout, m_overflow;
    logic [7:0]  m_tdata;
    logic [15:0] m_rounds, m_msgs;

    int         checks = 0;
    int         errors = 0;
    bit         sel = 1'b0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    ring_sequencer #(.DW(8), .FIFO_AW(4), .RESERVE(8), .TIMEOUT(40)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_last(last),
        .i_valid(valid), .i_token(token), .o_token(a_token), .o_tdata(a_tdata),
        .o_tlast(a_tlast), .o_tvalid(a_tvalid), .i_tready(tready),
        .o_rounds(a_rounds), .o_msgs(a_msgs), .o_timeout(a_timeout),
        .o_overflow(a_overflow)
    );

    ring_sequencer #(.DW(8), .FIFO_AW(2), .RESERVE(2), .TIMEOUT(10)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_last(last),
        .i_valid(valid), .i_token(token), .o_token(b_token), .o_tdata(b_tdata),
        .o_tlast(b_tlast), .o_tvalid(b_tvalid), .i_tready(tready),
        .o_rounds(b_rounds), .o_msgs(b_msgs), .o_timeout(b_timeout),
        .o_overflow(b_overflow)
    );

    assign m_token    = sel ? b_token    : a_token;
    assign m_tdata    = sel ? b_tdata    : a_tdata;
    assign m_tlast    = sel ? b_tlast    : a_tlast;
    assign m_tvalid   = sel ? b_tvalid   : a_tvalid;
    assign m_rounds   = sel ? b_rounds   : a_rounds;
    assign m_msgs     = sel ? b_msgs     : a_msgs;
    assign m_timeout  = sel ? b_timeout  : a_timeout;
    assign m_overflow = sel ? b_overflow : a_overflow;

    // Stream scoreboard: a handshake seen mid-cycle completes on the next edge.
    always @(negedge clk) begin
        if (m_tvalid && tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream_unexpected got %h want nothing", {m_tlast, m_tdata});
            end else begin
                logic [8:0] exp;
                exp = sb.pop_front();
                if ({m_tlast, m_tdata} !== exp) begin
                    errors++;
                    $display("FAIL stream_data got %h want %h", {m_tlast, m_tdata}, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l, input bit expect_out);
        data  = d;
        last  = l;
        valid = 1'b1;
        if (expect_out) sb.push_back({l, d});
        tick();
    endtask

    task automatic wait_token(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (m_token === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; valid = 1'b0; last = 1'b0; data = '0;
        token = 1'b0; tready = 1'b0;
        tick();
        sb.delete();
        checks++;
        if ({m_token, m_tvalid, m_rounds, m_msgs, m_timeout, m_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state got tok=%b tv=%b r=%0d m=%0d to=%b ov=%b want all 0",
                     m_token, m_tvalid, m_rounds, m_msgs, m_timeout, m_overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset;
        sel = 1'b0;
        do_reset();
        sel = 1'b1;
        do_reset();
    endtask

    task automatic test_basic_round;
        bit seen;
        sel = 1'b0;
        do_reset();
        en = 1'b1;
        wait_token(5, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL first_token got 0 want 1"); end
        tick();
        checks++;
        if (m_token !== 1'b0) begin errors++; $display("FAIL token_pulse_width got %b want 0", m_token); end
        repeat (18) tick();
        token = 1'b1;
        tick();
        token = 1'b0;
        checks++;
        if (m_rounds !== 16'd1 || m_token !== 1'b0) begin
            errors++;
            $display("FAIL round_count got r=%0d tok=%b want r=1 tok=0", m_rounds, m_token);
        end
        tick();
        checks++;
        if (m_token !== 1'b1) begin errors++; $display("FAIL reissue_latency got %b want 1", m_token); end
    endtask

    task automatic test_message_path;
        logic [7:0] msg [5];
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        tready = 1'b1;
        for (int i = 0; i < 5; i++) push(msg[i], (i == 4), 1'b1);
        valid = 1'b0;
        last  = 1'b0;
        repeat (6) tick();
        checks++;
        if (sb.size() != 0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL msg_drained got left=%0d tv=%b want 0 0", sb.size(), m_tvalid);
        end
        checks++;
        if (m_msgs !== 16'd1) begin errors++; $display("FAIL msg_count got %0d want 1", m_msgs); end
        tready = 1'b0;
    endtask

    task automatic test_reserve;
        bit seen;
        sel = 1'b0;
        do_reset();
        en = 1'b1;
        wait_token(5, seen);
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), 1'b0, 1'b1);
        valid = 1'b0;
        token = 1'b1;
        tick();
        token = 1'b0;
        checks++;
        if (m_rounds !== 16'd1) begin errors++; $display("FAIL reserve_round got %0d want 1", m_rounds); end
        wait_token(6, seen);
        checks++;
        if (seen) begin errors++; $display("FAIL reserve_block got token 1 want 0"); end
        tready = 1'b1;
        tick();
        tready = 1'b0;
        wait_token(4, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL reserve_release got token 0 want 1"); end
        tready = 1'b1;
        repeat (12) tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL reserve_drain got left=%0d want 0", sb.size()); end
        tready = 1'b0;
    endtask

    task automatic test_timeout;
        bit seen, early;
        sel = 1'b1;
        do_reset();
        en = 1'b1;
        wait_token(5, seen);
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_timeout !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL timeout_early got 1 want 0"); end
        tick();
        checks++;
        if (m_timeout !== 1'b1) begin errors++; $display("FAIL timeout_at_11 got %b want 1", m_timeout); end
        tick();
        checks++;
        if (m_token !== 1'b1 || m_rounds !== 16'd0) begin
            errors++;
            $display("FAIL regen_token got tok=%b r=%0d want tok=1 r=0", m_token, m_rounds);
        end
    endtask

    task automatic test_race;
        bit seen;
        sel = 1'b1;
        do_reset();
        en = 1'b1;
        wait_token(5, seen);
        repeat (10) tick();
        token = 1'b1;
        tick();
        token = 1'b0;
        checks++;
        if (m_rounds !== 16'd1 || m_timeout !== 1'b0) begin
            errors++;
            $display("FAIL race_return got r=%0d to=%b want r=1 to=0", m_rounds, m_timeout);
        end
    endtask

    task automatic test_overflow;
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), (i == 3), 1'b1);
        checks++;
        if (m_overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got 1 want 0"); end
        push(8'hA4, 1'b1, 1'b0);
        valid = 1'b0;
        last  = 1'b0;
        checks++;
        if (m_overflow !== 1'b1 || m_msgs !== 16'd1) begin
            errors++;
            $display("FAIL overflow_drop got ov=%b m=%0d want ov=1 m=1", m_overflow, m_msgs);
        end
        tready = 1'b1;
        repeat (8) tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL overflow_drain got left=%0d want 0", sb.size()); end
        tready = 1'b0;
    endtask

    task automatic test_mid_reset;
        bit seen;
        sel = 1'b0;
        do_reset();
        en = 1'b1;
        wait_token(5, seen);
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i), (i == 2), 1'b1);
        valid = 1'b0;
        last  = 1'b0;
        tick();
        checks++;
        if (m_msgs !== 16'd1 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got m=%0d tv=%b want m=1 tv=1", m_msgs, m_tvalid);
        end
        do_reset();
        token = 1'b1;
        tick();
        token = 1'b0;
        repeat (3) tick();
        checks++;
        if (m_rounds !== 16'd0 || m_token !== 1'b0) begin
            errors++;
            $display("FAIL stray_token got r=%0d tok=%b want r=0 tok=0", m_rounds, m_token);
        end
        tready = 1'b1;
        push(8'h5A, 1'b1, 1'b1);
        valid = 1'b0;
        last  = 1'b0;
        repeat (4) tick();
        checks++;
        if (sb.size() != 0 || m_msgs !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_write got left=%0d m=%0d want 0 1", sb.size(), m_msgs);
        end
        tready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; valid = 1'b0; last = 1'b0; data = '0;
        token = 1'b0; tready = 1'b0;
        test_reset();
        test_basic_round();
        test_message_path();
        test_reserve();
        test_timeout();
        test_race();
        test_overflow();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_sequencer.md
Name: ring_sequencer

Overview:
- Head-of-ring controller for the token-passing message chain.
- Owns the single circulating token and issues it to the first core.
- Detects the token's return from the last core, and regenerates it on loss (timeout).
- The ring has no backpressure, so ring bytes are buffered in a FIFO and drained on an AXI-Stream port toward the UART/host. A new token is issued only when the FIFO can absorb a full round of messages.

Parameters:
- DW, 8, ring/stream data width.
- FIFO_AW, 9, FIFO address width; depth = 2**FIFO_AW entries of {last,data}.
- RESERVE, 256, minimum free FIFO entries required before issuing a token (worst-case bytes in one round).
- TIMEOUT, 65535, cycles to wait for token return before regeneration; 1..2**24-1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_en  in  1  enable token issue
- i_data  in  DW  ring byte from last core
- i_last  in  1  last byte of a message
- i_valid  in  1  ring byte valid (no backpressure)
- i_token  in  1  token returned from last core (1-cycle pulse)
- o_token  out  1  token to first core (1-cycle pulse, registered)
- o_tdata  out  DW  stream data
- o_tlast  out  1  stream last
- o_tvalid  out  1  stream valid
- i_tready  in  1  stream ready
- o_rounds  out  16  completed rounds (token returned), wraps
- o_msgs  out  16  messages accepted into FIFO (i_last writes), wraps
- o_timeout  out  1  sticky: at least one token regenerated
- o_overflow  out  1  sticky: at least one ring byte dropped

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE, o_token=0, FIFO empty (o_tvalid=0), o_rounds=0, o_msgs=0, o_timeout=0, o_overflow=0, timer=0. Reset mid-round abandons the round; bytes arriving after reset are written normally.
- FSM:
  - IDLE: if i_en && free>=RESERVE -> ISSUE, else stay.
  - ISSUE: o_token=1 for exactly this cycle; timer<=TIMEOUT-1; -> WAIT.
  - WAIT:
    - i_token=1 -> o_rounds+1, -> IDLE.
    - Else if timer==0 -> o_timeout<=1, -> IDLE (token regenerated on next issue).
    - Else timer-1.
    - i_token and timer==0 in the same cycle: return wins (count round, no timeout).
- Latency: i_token high in cycle n (WAIT) -> earliest o_token in cycle n+2. Free space is evaluated in IDLE using the current count.
- i_token outside WAIT: ignored, no counter change.
- i_en low: no new issue; a round already in WAIT completes or times out normally.
- FIFO write: each cycle with i_valid, {i_last,i_data} is written iff count<depth before this cycle's read. If full, the byte is dropped and o_overflow<=1; a read in the same cycle does not rescue it.
- o_msgs increments on each accepted write with i_last=1. A dropped last byte is not counted.
- FIFO read: first-word fall-through; o_tvalid = count!=0. Pop on o_tvalid&&i_tready. o_tdata/o_tlast stay stable while o_tvalid&&!i_tready.
- Simultaneous write and read: count unchanged, both pointers advance; a write to an empty FIFO is visible on o_tvalid the next cycle.
- free = depth-count, width FIFO_AW+1.
- Pointers wrap modulo depth.
- Counters wrap 0xFFFF->0 silently.

Decomposition:
- Package ring_sequencer_pkg: state enum (IDLE, ISSUE, WAIT), timer width constant (24), counter width constant (16).
- Sub-module ring_fifo: sync FWFT FIFO; params DW+1, FIFO_AW; ports for write, read, count. All FSM and counters live in the top.

Test Plan:
- Basic round: reset, i_en=1, empty FIFO -> o_token pulse 1 cycle. Return i_token 20 cycles later -> o_rounds=1, next o_token exactly 2 cycles after i_token.
- Message path: in WAIT, drive 5 bytes 0x48,0x65,0x6C,0x6C,0x6F, i_last on 0x6F, i_tready=1 -> same bytes out in order, o_tlast only on 0x6F, o_msgs=1.
- Backpressure/reserve: FIFO_AW=4, RESERVE=8, i_tready=0, push 9 bytes -> after token return no o_token (free=7). Raise i_tready for 1 pop -> o_token issued.
- Timeout: TIMEOUT=10, never return token -> o_timeout=1 on the 11th cycle after issue, new o_token 1 cycle later, o_rounds=0.
- Overflow: FIFO_AW=2, i_tready=0, 5 consecutive valid bytes -> first 4 stored, 5th dropped, o_overflow=1. A 5th byte with i_last=1 leaves o_msgs unchanged.
- Mid-operation reset and races: assert i_rst in WAIT with 3 bytes buffered -> next cycle all outputs at reset values. i_token coincident with timer==0 -> o_rounds+1, o_timeout stays 0.
